// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Multi-cycle magnitude comparator for two WIDTH-bit operands. The operands
//   are captured on start, then scanned MSB-first one DIGIT-bit slice per
//   clock. The scan stops at the first slice that differs, or after the last
//   slice if all of them are equal. Unsigned and two's-complement compares are
//   selected per operation.
//
// Parameters
//   WIDTH        operand width; must be >= 2 and a multiple of DIGIT
//   DIGIT        bits compared per clock (NDIG = WIDTH/DIGIT slices)
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request; sampled only while idle
//   signed_mode  1 = two's-complement, 0 = unsigned; captured with start
//   a, b         operands; captured with start
//   busy         high while a compare is in progress
//   done         one-cycle pulse when lt/eq/gt are updated
//   lt, eq, gt   registered result of the last completed compare
module serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]                  state;
    logic [IW-1:0]               index;
    logic [NDIG-1:0][DIGIT-1:0]  a_q;
    logic [NDIG-1:0][DIGIT-1:0]  b_q;
    logic [DIGIT-1:0]            a_dig;
    logic [DIGIT-1:0]            b_dig;
    logic [WIDTH-1:0]            msb_flip;

    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned order, so the scan itself is always an unsigned compare.
    assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    assign a_dig = a_q[index];
    assign b_dig = b_q[index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            index <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a ^ msb_flip;
                        b_q   <= b ^ msb_flip;
                        index <= LAST;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (a_dig != b_dig) begin
                        lt    <= (a_dig < b_dig);
                        gt    <= (a_dig > b_dig);
                        eq    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (index == '0) begin
                        lt    <= 1'b0;
                        eq    <= 1'b1;
                        gt    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        index <= index - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator
//   Directed bench for serial_magnitude_comparator. Two instances: an 8-bit
//   one scanning one bit per clock and a 16-bit one scanning 4 bits per clock.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    logic rst;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, lt8, eq8, gt8;

    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic        busy16, done16, lt16, eq16, gt16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .lt(lt8), .eq(eq8), .gt(gt8)
    );

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .lt(lt16), .eq(eq16), .gt(gt16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one compare and waits (bounded) for done. Returns the number of
    // edges from the start edge to the decision edge (0 = timeout), the result
    // as {lt,eq,gt}, and whether busy/done behaved as a clean handshake.
    task automatic run(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                       input bit sm, output int cyc, output logic [2:0] res,
                       output bit hs_ok);
        if (w16) begin start16 = 1'b1; a16 = av; b16 = bv; sm16 = sm; end
        else     begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm; end
        tick();
        start8 = 1'b0; start16 = 1'b0;
        hs_ok = w16 ? (busy16 && !done16) : (busy8 && !done8);
        cyc = 0;
        res = 3'b000;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (w16 ? done16 : done8) begin
                cyc = i;
                res = w16 ? {lt16, eq16, gt16} : {lt8, eq8, gt8};
                hs_ok = hs_ok && !(w16 ? busy16 : busy8);
                break;
            end
            hs_ok = hs_ok && (w16 ? busy16 : busy8);
        end
        tick();
        hs_ok = hs_ok && !(w16 ? done16 : done8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        tick(); tick();
        total++;
        if ({busy8, done8, lt8, eq8, gt8} !== 5'b0) begin
            bad++; $display("FAIL reset8 got=%b want=00000", {busy8, done8, lt8, eq8, gt8});
        end
        total++;
        if ({busy16, done16, lt16, eq16, gt16} !== 5'b0) begin
            bad++; $display("FAIL reset16 got=%b want=00000", {busy16, done16, lt16, eq16, gt16});
        end
        rst = 1'b0;
        tick();
    endtask

    // One compare: check latency, {lt,eq,gt} and handshake.
    task automatic test_vec(input string name, input bit w16, input logic [15:0] av,
                            input logic [15:0] bv, input bit sm, input int exp_cyc,
                            input logic [2:0] exp_res);
        int cyc; logic [2:0] res; bit hs;
        run(w16, av, bv, sm, cyc, res, hs);
        total++;
        if (cyc !== exp_cyc) begin
            bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, exp_cyc);
        end
        total++;
        if (res !== exp_res) begin
            bad++; $display("FAIL %s_result got=%b want=%b", name, res, exp_res);
        end
        total++;
        if (hs !== 1'b1) begin
            bad++; $display("FAIL %s_handshake got=%b want=1", name, hs);
        end
    endtask

    // start and operand changes during a scan must not disturb it.
    task automatic test_busy_ignore();
        int cyc = 0; logic [2:0] res = 3'b000;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h11; sm8 = 1'b0;
        tick();
        start8 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b1; end
            if (i == 5) begin start8 = 1'b0; end
            tick();
            if (done8) begin cyc = i; res = {lt8, eq8, gt8}; break; end
        end
        start8 = 1'b0;
        total++;
        if (cyc !== 8) begin
            bad++; $display("FAIL busy_ignore_latency got=%0d want=8", cyc);
        end
        total++;
        if (res !== 3'b100) begin
            bad++; $display("FAIL busy_ignore_result got=%b want=100", res);
        end
        tick();
        total++;
        if ({busy8, done8} !== 2'b00) begin
            bad++; $display("FAIL busy_ignore_idle got=%b want=00", {busy8, done8});
        end
    endtask

    // start raised in the done cycle is accepted at the very next edge.
    task automatic test_back_to_back();
        int cyc = 0; logic [2:0] res = 3'b000;
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; sm8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        total++;
        if ({done8, gt8} !== 2'b11) begin
            bad++; $display("FAIL b2b_first got=%b want=11", {done8, gt8});
        end
        // 0x40 vs 0x60 first differ at bit 5: third slice examined.
        start8 = 1'b1; a8 = 8'h40; b8 = 8'h60;
        tick();
        start8 = 1'b0;
        total++;
        if ({busy8, done8, lt8, eq8, gt8} !== 5'b10001) begin
            bad++; $display("FAIL b2b_accept got=%b want=10001", {busy8, done8, lt8, eq8, gt8});
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done8) begin cyc = i; res = {lt8, eq8, gt8}; break; end
        end
        total++;
        if (cyc !== 3) begin
            bad++; $display("FAIL b2b_latency got=%0d want=3", cyc);
        end
        total++;
        if (res !== 3'b100) begin
            bad++; $display("FAIL b2b_result got=%b want=100", res);
        end
        tick();
    endtask

    // Async reset during a scan clears everything at once and kills the compare.
    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        start8 = 1'b1; a8 = 8'hA5; b8 = 8'hA5; sm8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        total++;
        if ({busy8, done8, lt8, eq8, gt8} !== 5'b0) begin
            bad++; $display("FAIL reset_mid_clear got=%b want=00000", {busy8, done8, lt8, eq8, gt8});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++; $display("FAIL reset_mid_no_done got=%b want=0", saw_done);
        end
        test_vec("after_reset", 1'b0, 16'h0080, 16'h007F, 1'b0, 1, 3'b001);
    endtask

    initial begin
        test_reset();
        test_vec("u8_msb",      1'b0, 16'h0080, 16'h007F, 1'b0, 1, 3'b001);
        test_vec("s8_msb",      1'b0, 16'h0080, 16'h007F, 1'b1, 1, 3'b100);
        test_vec("u8_equal",    1'b0, 16'h00A5, 16'h00A5, 1'b0, 8, 3'b010);
        test_vec("u8_lsb",      1'b0, 16'h00A4, 16'h00A5, 1'b0, 8, 3'b100);
        test_vec("s8_neg",      1'b0, 16'h00FF, 16'h00FE, 1'b1, 8, 3'b001);
        test_vec("u16_d4",      1'b1, 16'h12F0, 16'h1300, 1'b0, 2, 3'b100);
        test_vec("u16_equal",   1'b1, 16'h5A3C, 16'h5A3C, 1'b0, 4, 3'b010);
        test_vec("s16_sign",    1'b1, 16'h8000, 16'h0001, 1'b1, 1, 3'b100);
        test_vec("u16_lowdig",  1'b1, 16'h0009, 16'h0003, 1'b0, 4, 3'b001);
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
